// File: rtl/bram_rd_arbiter.sv
// rtl/bram_rd_arbiter.sv - round-robin read arbiter sharing one BRAM read port between two CSR engines
//
// Purpose:
//   Two CSR traversal engines share the single read port of the transition-table
//   BRAM. One read is issued per cycle. Every issued read carries a small tag
//   (valid + requester id) through a shift pipeline matching the BRAM latency,
//   so the returned row can be steered back to the requester that asked for it.
//   A requester may hold lock_x to keep the port for up to MAX_BURST consecutive
//   grants.
//
// Ports:
//   clk                 clock, all state on its rising edge
//   reset               asynchronous reset, active low
//   req_0 / req_1       read request, held until granted
//   addr_0 / addr_1     row address, stable while req is high
//   lock_0 / lock_1     ask for a locked burst, sampled with req
//   gnt_0 / gnt_1       combinational grant, request consumed this cycle
//   rvalid_0 / rvalid_1 returned row belongs to this requester
//   rdata               returned row (passthrough of bram_dout)
//   bram_en             registered BRAM read enable
//   bram_addr           registered BRAM read address
//   bram_dout           BRAM read data

module bram_rd_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 512,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic              lock_0,
  input  logic              lock_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  // ST_BURST is the "owner valid" condition: a locked owner holds the port.
  typedef enum logic {
    ST_OPEN  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [RD_LAT:0]    tag_v_q, tag_v_d;
  logic [RD_LAT:0]    tag_id_q, tag_id_d;
  logic               bram_en_q, bram_en_d;
  logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;

  logic               gnt_any;
  logic               gnt_id;
  logic               req_own;
  logic               lock_own;
  logic               cont;

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_OPEN;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;   // requester 0 wins the first arbitration
      burst_cnt_q <= '0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      bram_en_q   <= bram_en_d;
      bram_addr_q <= bram_addr_d;
    end
  end

  // ------------------------------------------------------------------
  // Arbitration, burst tracking and issue
  // ------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    gnt_any     = 1'b0;
    gnt_id      = 1'b0;

    req_own  = owner_q ? req_1  : req_0;
    lock_own = owner_q ? lock_1 : lock_0;
    cont     = (state_q == ST_BURST) && req_own && lock_own && (burst_cnt_q < MAX_CNT);

    if (cont) begin
      gnt_any     = 1'b1;
      gnt_id      = owner_q;
      burst_cnt_d = burst_cnt_q + ONE_CNT;
    end else begin
      // Any cycle that fails the continuation ends the burst and arbitrates
      // normally in the same cycle. Since last equals the owner, the other
      // requester wins here if it is waiting, so burst ends cost no bubble.
      state_d     = ST_OPEN;
      burst_cnt_d = '0;
      if (req_0 && req_1) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_q;
      end else if (req_0) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (req_1) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
      if (gnt_any && (gnt_id ? lock_1 : lock_0)) begin
        state_d     = ST_BURST;
        owner_d     = gnt_id;
        burst_cnt_d = ONE_CNT;
      end
    end

    if (gnt_any) begin
      last_d = gnt_id;
    end

    // The read port registers the address; it holds when nothing is granted.
    bram_en_d   = gnt_any;
    bram_addr_d = gnt_any ? (gnt_id ? addr_1 : addr_0) : bram_addr_q;

    // Tags enter stage 0 together with the registered address and reach the
    // last stage exactly when the BRAM presents the corresponding row.
    tag_v_d  = {tag_v_q[RD_LAT-1:0], gnt_any};
    tag_id_d = {tag_id_q[RD_LAT-1:0], gnt_id};
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // Grants are gated by reset so nothing is consumed while reset is held.
  assign gnt_0 = reset & gnt_any & ~gnt_id;
  assign gnt_1 = reset & gnt_any &  gnt_id;

  assign rvalid_0 = tag_v_q[RD_LAT] & ~tag_id_q[RD_LAT];
  assign rvalid_1 = tag_v_q[RD_LAT] &  tag_id_q[RD_LAT];
  assign rdata    = bram_dout;

  assign bram_en   = bram_en_q;
  assign bram_addr = bram_addr_q;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// tb/tb_bram_rd_arbiter.sv - scoreboard bench for bram_rd_arbiter

module tb_bram_rd_arbiter;

  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 512;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;
  localparam logic [DATA_W-1:0] JUNK = {(DATA_W/32){32'hDEADBEEF}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance (default parameters)
  logic              reset;
  logic              req_0, req_1, lock_0, lock_1;
  logic [ADDR_W-1:0] addr_0, addr_1;
  logic              gnt_0, gnt_1, rvalid_0, rvalid_1, bram_en;
  logic [DATA_W-1:0] rdata, bram_dout;
  logic [ADDR_W-1:0] bram_addr;

  bram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .addr_0(addr_0), .addr_1(addr_1),
    .lock_0(lock_0), .lock_1(lock_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata(rdata), .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout)
  );

  // RD_LAT = 1 instance
  logic              l_reset;
  logic              l_req_0, l_req_1, l_lock_0, l_lock_1;
  logic [ADDR_W-1:0] l_addr_0, l_addr_1;
  logic              l_gnt_0, l_gnt_1, l_rvalid_0, l_rvalid_1, l_bram_en;
  logic [DATA_W-1:0] l_rdata, l_dout;
  logic [ADDR_W-1:0] l_bram_addr;

  bram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .MAX_BURST(MAX_BURST)) dut_l1 (
    .clk(clk), .reset(l_reset),
    .req_0(l_req_0), .req_1(l_req_1), .addr_0(l_addr_0), .addr_1(l_addr_1),
    .lock_0(l_lock_0), .lock_1(l_lock_1),
    .gnt_0(l_gnt_0), .gnt_1(l_gnt_1), .rvalid_0(l_rvalid_0), .rvalid_1(l_rvalid_1),
    .rdata(l_rdata), .bram_en(l_bram_en), .bram_addr(l_bram_addr), .bram_dout(l_dout)
  );

  // table contents: a fixed function of the row address
  function automatic logic [DATA_W-1:0] row(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++)
      r[i*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(i) * 32'h01010101) ^ 32'h5A000000;
    return r;
  endfunction

  // BRAM models: address sampled at an edge, row visible RD_LAT cycles after the address cycle
  logic [DATA_W-1:0] bpipe [RD_LAT];
  always @(posedge clk) begin
    bpipe[0] <= bram_en ? row(bram_addr) : JUNK;
    for (int i = 1; i < RD_LAT; i++) bpipe[i] <= bpipe[i-1];
  end
  assign bram_dout = bpipe[RD_LAT-1];

  always @(posedge clk) l_dout <= l_bram_en ? row(l_bram_addr) : JUNK;

  // checking bookkeeping
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk_row(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act[63:0], exp[63:0], cyc);
  endtask

  // reference model: arbitration rules with plain integers
  int m_last = 1, m_ov = 0, m_owner = 0, m_cnt = 0;

  task automatic model_arb(input bit r0, input bit r1, input bit l0, input bit l1, output int g);
    bit rq [2];
    bit lk [2];
    bit cont;
    rq[0] = r0; rq[1] = r1; lk[0] = l0; lk[1] = l1;
    cont = (m_ov != 0) && rq[m_owner] && lk[m_owner] && (m_cnt < MAX_BURST);
    if (cont)          g = m_owner;
    else if (r0 && r1) g = 1 - m_last;
    else if (r0)       g = 0;
    else if (r1)       g = 1;
    else               g = -1;
    if (g >= 0) m_last = g;
    if (cont) m_cnt++;
    else begin
      m_ov = 0; m_cnt = 0;
      if (g >= 0 && lk[g]) begin m_ov = 1; m_owner = g; m_cnt = 1; end
    end
  endtask

  typedef struct {
    int                due;
    int                id;
    logic [ADDR_W-1:0] addr;
  } item_t;

  item_t iss_q [$];
  item_t ret_q [$];
  int    exp_g = -1;
  int    obs [$];
  logic [ADDR_W-1:0] na0, na1;

  // drive one cycle of requests; expected responses go into the scoreboard
  task automatic step(input bit r0, input bit r1, input bit l0, input bit l1, output int g);
    item_t it;
    req_0 = r0; req_1 = r1; lock_0 = l0; lock_1 = l1;
    addr_0 = na0; addr_1 = na1;
    model_arb(r0, r1, l0, l1, g);
    exp_g = g;
    if (g >= 0) begin
      it.id   = g;
      it.addr = (g == 1) ? na1 : na0;
      it.due  = cyc + 1;
      iss_q.push_back(it);
      it.due  = cyc + 1 + RD_LAT;
      ret_q.push_back(it);
    end
    @(posedge clk); #1;
    exp_g = -1;
  endtask

  task automatic pulse_reset(input bit check_now);
    reset = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_async_gnt", {gnt_1, gnt_0}, 0);
      chk("rst_async_rvalid", {rvalid_1, rvalid_0}, 0);
      chk("rst_async_en", bram_en, 0);
    end
    req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0;
    exp_g = -1;
    iss_q.delete(); ret_q.delete();
    m_last = 1; m_ov = 0; m_cnt = 0; m_owner = 0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic check_seq(input string nm, input string e);
    string got;
    got = "";
    foreach (obs[i]) got = {got, (obs[i] == 1) ? "1" : "0"};
    n_chk++;
    if (got == e) n_pass++;
    else $display("FAIL %s: grant order got %s expected %s", nm, got, e);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents issue/return activity
  always @(negedge clk) begin : mon
    int    gid;
    item_t it;
    if (!reset) begin
      chk("rst_gnt", {gnt_1, gnt_0}, 0);
      chk("rst_rvalid", {rvalid_1, rvalid_0}, 0);
      chk("rst_en", bram_en, 0);
      chk("rst_addr", bram_addr, 0);
    end else begin
      gid = (gnt_0 && gnt_1) ? 2 : gnt_1 ? 1 : gnt_0 ? 0 : -1;
      chk("gnt", gid, exp_g);
      if (gid == 0 || gid == 1) obs.push_back(gid);
      if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
        it = iss_q.pop_front();
        chk("issue_en", bram_en, 1);
        chk("issue_addr", bram_addr, it.addr);
      end else begin
        chk("idle_en", bram_en, 0);
      end
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        it = ret_q.pop_front();
        chk("rvalid", {rvalid_1, rvalid_0}, (it.id == 1) ? 2 : 1);
        chk_row("rdata", rdata, row(it.addr));
      end else begin
        chk("no_rvalid", {rvalid_1, rvalid_0}, 0);
      end
    end
  end

  // RD_LAT = 1 directed check
  bit l1_done = 0;
  initial begin : l1_test
    int t1;
    logic [ADDR_W-1:0] a;
    l_reset = 0; l_req_0 = 0; l_req_1 = 0; l_lock_0 = 0; l_lock_1 = 0;
    l_addr_0 = '0; l_addr_1 = '0;
    repeat (2) @(posedge clk);
    #1 l_reset = 1;
    @(posedge clk); #1;
    a = 17'h155AA;
    l_req_1 = 1; l_addr_1 = a; t1 = cyc;
    #1 chk("l1_gnt", {l_gnt_1, l_gnt_0}, 2);
    @(posedge clk); #1;
    l_req_1 = 0;
    repeat (6) begin
      @(negedge clk);
      chk("l1_rvalid", {l_rvalid_1, l_rvalid_0}, (cyc == t1 + 2) ? 2 : 0);
      if (cyc == t1 + 2) begin
        chk_row("l1_rdata", l_rdata, row(a));
        chk_row("l1_passthru", l_rdata, l_dout);
      end
    end
    l1_done = 1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int g;
    bit pend0, pend1, lk0, lk1;
    reset = 0; req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0;
    addr_0 = '0; addr_1 = '0; na0 = '0; na1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1;

    // requester 0 alone, addresses 0..4
    obs.delete();
    for (int k = 0; k < 5; k++) begin
      na0 = 17'(k);
      step(1, 0, 0, 0, g);
    end
    repeat (6) step(0, 0, 0, 0, g);
    check_seq("solo", "00000");

    // both requesting from reset, no lock
    pulse_reset(0);
    obs.delete();
    na0 = 100; na1 = 200;
    repeat (6) begin
      step(1, 1, 0, 0, g);
      if (g == 0) na0++; else if (g == 1) na1++;
    end
    repeat (5) step(0, 0, 0, 0, g);
    check_seq("alternate", "010101");

    // lock_0 held with both requesting
    obs.delete();
    na0 = 300; na1 = 400;
    repeat (10) begin
      step(1, 1, 1, 0, g);
      if (g == 0) na0++; else if (g == 1) na1++;
    end
    repeat (5) step(0, 0, 0, 0, g);
    check_seq("lock_burst", "0000100001");

    // lock_0 dropped after two burst grants while req_1 pending
    obs.delete();
    step(1, 1, 1, 0, g); na0++;
    step(1, 1, 1, 0, g); na0++;
    step(1, 1, 0, 0, g);
    repeat (5) step(0, 0, 0, 0, g);
    check_seq("lock_drop", "001");

    // reset with reads in flight
    repeat (3) begin
      step(1, 1, 0, 0, g);
      if (g == 0) na0++; else if (g == 1) na1++;
    end
    pulse_reset(1);
    obs.delete();
    repeat (2) begin
      step(1, 1, 0, 0, g);
      if (g == 0) na0++; else if (g == 1) na1++;
    end
    repeat (5) step(0, 0, 0, 0, g);
    check_seq("post_reset", "01");

    // randomized traffic
    pend0 = 0; pend1 = 0;
    for (int it = 0; it < 400; it++) begin
      if (it == 200) pulse_reset(1);
      if (!pend0 && $urandom_range(0, 3) != 0) begin pend0 = 1; na0 = 17'($urandom); end
      if (!pend1 && $urandom_range(0, 3) != 0) begin pend1 = 1; na1 = 17'($urandom); end
      lk0 = pend0 && ($urandom_range(0, 2) != 0);
      lk1 = pend1 && ($urandom_range(0, 2) != 0);
      step(pend0, pend1, lk0, lk1, g);
      if (g == 0) pend0 = 0; else if (g == 1) pend1 = 0;
    end
    repeat (6) step(0, 0, 0, 0, g);

    chk("scoreboard_drained", iss_q.size() + ret_q.size(), 0);
    chk("l1_done", l1_done, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bram_rd_arbiter.md
# bram_rd_arbiter

Round-robin read arbiter that shares the single read port of the CSR transition-table BRAM (512-bit rows, 17-bit address) between two CSR traversal engines. Each engine scans its own input trace and needs table rows every character. The arbiter issues one read per cycle, tracks the owner of every in-flight read through the fixed BRAM latency, and steers the returned row back to that owner. It supports short locked bursts so one engine can fetch consecutive rows without interleaving.

## Interface
Parameters:
- ADDR_W, 17, BRAM address width
- DATA_W, 512, BRAM row width
- RD_LAT, 2, BRAM cycles from `bram_addr` sampled to `bram_dout` valid (≥1)
- MAX_BURST, 4, maximum consecutive grants to a locked owner (≥1)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- req_0 / req_1  in  1  read request; held until granted
- addr_0 / addr_1  in  ADDR_W  row address; stable while req high
- lock_0 / lock_1  in  1  request a locked burst; sampled with req
- gnt_0 / gnt_1  out  1  combinational grant; request is consumed this cycle
- rvalid_0 / rvalid_1  out  1  returned row belongs to this requester
- rdata  out  DATA_W  returned row; passthrough of `bram_dout`, shared by both requesters
- bram_en  out  1  registered read enable
- bram_addr  out  ADDR_W  registered read address
- bram_dout  in  DATA_W  BRAM read data

## Operation
- State:
  - `last`: id of the last granted requester; resets to 1, so requester 0 wins first.
  - `owner_valid`, `owner`: locked-burst owner.
  - `burst_cnt`: 0..MAX_BURST.
  - `tag_v`, `tag_id`: shift pipeline of depth RD_LAT+1.
- Arbitration, evaluated every cycle, at most one grant:
  - Burst continuation: `owner_valid`, req_owner high, lock_owner high, and burst_cnt < MAX_BURST. Grant the owner and increment burst_cnt.
  - Otherwise, with one request pending: grant it.
  - Otherwise, with both pending: grant the requester ≠ `last`.
  - Otherwise, with no request: no grant.
- On any grant, set `last` to the granted id.
- Burst start: a grant outside a burst where lock_x is high sets owner = x, `owner_valid` = 1, burst_cnt = 1.
- Burst end: the burst ends (`owner_valid` cleared, burst_cnt = 0) in any cycle the continuation condition fails. The cycle that fails it arbitrates normally. `last` = owner, so the other requester wins that cycle if it is requesting.
- A lock from the non-owner is ignored during a burst.
- Issue: on a grant, the next edge loads `bram_en` = 1, `bram_addr` = granted addr, and `tag` stage 0 = {1, id}. With no grant, `bram_en` = 0 and `bram_addr` holds its previous value.
- Return: `tag` shifts every cycle. rvalid_x = tag_v[last stage] & (tag_id == x). At most one rvalid is high per cycle.
- No backpressure on the return path. Requesters must accept data on rvalid.

## Timing
- Reset values: gnt_0 = gnt_1 = 0 while reset is low. rvalid_0, rvalid_1, bram_en, bram_addr, and all tags = 0. last = 1, owner_valid = 0, burst_cnt = 0.
- Grant at edge-cycle T:
  - bram_addr/bram_en valid in cycle T+1.
  - rvalid_x and rdata valid in cycle T+1+RD_LAT, so T+3 at default.
- Throughput: one read per cycle sustained; no bubbles between grants, including requester switches and burst ends.
- Reset mid-operation: asserting reset clears outputs and tags asynchronously. In-flight reads are dropped and never produce rvalid. After release, the first grant goes to requester 0.
- A request is consumed only in the cycle its gnt is high. The requester then drops req or presents the next address.

## Test plan
- Requester 0 alone, req_0 held 5 cycles, addr_0 = 0..4 → gnt_0 high 5 consecutive cycles. bram_addr = 0..4 on cycles T+1..T+5. rvalid_0 on T+3..T+7 with rdata equal to the rows at 0..4. rvalid_1 is never high.
- Both requesting continuously, no lock, from reset → grants 0,1,0,1,0,1. bram_addr alternates between addr_0 and addr_1. rvalid alternates with 3-cycle latency.
- Both requesting, lock_0 held high, MAX_BURST = 4 → gnt_0 ×4, gnt_1 ×1, gnt_0 ×4, gnt_1 ×1. bram_en is continuously 1.
- lock_0 dropped after 2 burst grants while req_1 is pending → the third grant goes to requester 1 in the drop cycle, with no idle cycle.
- Two reads in flight, reset pulsed low for 1 cycle → rvalid_0/rvalid_1 and bram_en go 0 immediately. No rvalid appears afterwards. Both requesting after release → first gnt_0.
- RD_LAT = 1 build, single grant to requester 1 at T → rvalid_1 only at T+2, with rdata = bram_dout of that cycle.
